// File: rtl/rr_hold_arbiter.sv
// Round-robin shared hold register: N requesters load one W-bit register, presented with valid/ready.
// A word granted at edge k is on q after edge k; while q is unconsumed and q_ready=0, no grants.
module rr_hold_arbiter #(
  parameter int  N  = 4,
  parameter int  W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  din,
  output logic [N-1:0]    gnt,
  output logic [W-1:0]    q,
  output logic [SW-1:0]   q_src,
  output logic            q_valid,
  input  logic            q_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [SW-1:0]  ptr;
  logic [SW-1:0]  winner;
  logic [SW:0]    sum;
  logic           found;
  logic           load;

  assign q_valid = (state == FULL);

  // Rotating priority search starting at ptr, wrapping modulo N.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (SW+1)'(k);
      if (sum >= (SW+1)'(N)) sum = sum - (SW+1)'(N);
      if (!found && req[sum[SW-1:0]]) begin
        found  = 1'b1;
        winner = sum[SW-1:0];
      end
    end
  end

  // rst_n gates load so no grant leaks out while reset is held.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    gnt       = '0;
    if (rst_n && found && (state == EMPTY || q_ready)) load = 1'b1;
    if (load) gnt = {{(N-1){1'b0}}, 1'b1} << winner;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (q_ready && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      q     <= '0;
      q_src <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        q     <= din[int'(winner)*W +: W];
        q_src <= winner;
        if (winner == SW'(N-1)) ptr <= '0;
        else                    ptr <= winner + SW'(1);
      end
    end
  end

endmodule
